// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer
// Initiator-side driver for a pipelined adder tree. Serial signed addends
// are packed LENGTH at a time into one addend vector. Each full vector is
// issued to the tree. A tag shift register tracks the vector through the
// tree's pipeline, and the finished sum is returned on a valid/ready output
// that supports back-pressure.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// when valid and ready are both 1 in the cycle before that edge. Once valid
// is raised, the source holds valid and data stable until the transfer.
// ready may depend combinationally on internal state only, never on valid.
//
// LENGTH must be at least 2, so the tree latency is at least one advance.
module adder_tree_sequencer #(
    parameter int DATA_WIDTH = 5,
    parameter int LENGTH     = 9,
    parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         tree_reset,
    output logic                         tree_advance,
    output logic signed [DATA_WIDTH-1:0] tree_addends [LENGTH],
    input  logic signed [OUT_WIDTH-1:0]  tree_sum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_sum
);

    localparam int LATENCY = $clog2(LENGTH);
    localparam int CW      = $clog2(LENGTH + 1);
    localparam logic [CW-1:0] FULL = CW'(LENGTH);

    // Fill position of the vector being assembled (0..LENGTH)
    logic [CW-1:0]      count;
    // One bit per tree stage; the top bit marks a real sum on tree_sum
    logic [LATENCY-1:0] tag;

    logic tag_tail;
    logic capture;
    logic issue;
    logic accept;
    logic pop;

    // Control decode: the tree only stalls when a finished sum has nowhere to go
    always_comb begin
        tag_tail     = tag[LATENCY-1];
        tree_reset   = !reset;
        capture      = reset && tag_tail && (!out_valid || out_ready);
        tree_advance = reset && (!tag_tail || capture);
        in_ready     = (count < FULL);
        accept       = in_valid && in_ready;
        issue        = (count == FULL) && tree_advance;
        pop          = out_valid && out_ready;
    end

    // Fill counter: counts accepted addends, clears when the vector is issued
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (issue) begin
            count <= '0;
        end else if (accept) begin
            count <= count + CW'(1);
        end
    end

    // Addend vector: element i holds the i-th accepted addend of the group
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                tree_addends[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (count == CW'(i)) begin
                    tree_addends[i] <= in_data;
                end
            end
        end
    end

    // Tag shift register: moves in lock-step with the tree's advance.
    // Partial vectors still enter the tree, but with a 0 tag, so their sums are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag <= '0;
        end else if (tree_advance) begin
            tag[0] <= issue;
            for (int k = 1; k < LATENCY; k++) begin
                tag[k] <= tag[k-1];
            end
        end
    end

    // Output holding register: a capture wins over a pop, so a sum is never dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_sum   <= tree_sum;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
module tb_adder_tree_sequencer;

  localparam int DW_A  = 5;
  localparam int LEN_A = 9;
  localparam int OW_A  = 9;
  localparam int LAT_A = 4;
  localparam int DW_B  = 4;
  localparam int LEN_B = 2;
  localparam int OW_B  = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- instance A (default parameters) ----------------
  logic                   a_in_valid = 1'b0;
  logic                   a_in_ready;
  logic signed [DW_A-1:0] a_in_data = '0;
  logic                   a_tree_reset;
  logic                   a_tree_advance;
  logic signed [DW_A-1:0] a_tree_addends [LEN_A];
  logic signed [OW_A-1:0] a_tree_sum;
  logic                   a_out_valid;
  logic                   a_out_ready = 1'b1;
  logic signed [OW_A-1:0] a_out_sum;

  adder_tree_sequencer #(.DATA_WIDTH(DW_A), .LENGTH(LEN_A), .OUT_WIDTH(OW_A)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .tree_reset(a_tree_reset), .tree_advance(a_tree_advance),
    .tree_addends(a_tree_addends), .tree_sum(a_tree_sum),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum)
  );

  // Adder tree model for A: LAT_A stages that move only on advance
  logic signed [OW_A-1:0] a_stage [LAT_A];
  logic signed [OW_A-1:0] a_next;
  always_comb begin
    a_next = '0;
    for (int i = 0; i < LEN_A; i++) a_next = a_next + OW_A'(a_tree_addends[i]);
  end
  always @(posedge clk) begin
    if (a_tree_reset) begin
      for (int k = 0; k < LAT_A; k++) a_stage[k] <= '0;
    end else if (a_tree_advance) begin
      a_stage[0] <= a_next;
      for (int k = 1; k < LAT_A; k++) a_stage[k] <= a_stage[k-1];
    end
  end
  assign a_tree_sum = a_stage[LAT_A-1];

  // ---------------- instance B (LENGTH=2, DATA_WIDTH=4) ----------------
  logic                   b_in_valid = 1'b0;
  logic                   b_in_ready;
  logic signed [DW_B-1:0] b_in_data = '0;
  logic                   b_tree_reset;
  logic                   b_tree_advance;
  logic signed [DW_B-1:0] b_tree_addends [LEN_B];
  logic signed [OW_B-1:0] b_tree_sum;
  logic                   b_out_valid;
  logic                   b_out_ready = 1'b1;
  logic signed [OW_B-1:0] b_out_sum;

  adder_tree_sequencer #(.DATA_WIDTH(DW_B), .LENGTH(LEN_B), .OUT_WIDTH(OW_B)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .tree_reset(b_tree_reset), .tree_advance(b_tree_advance),
    .tree_addends(b_tree_addends), .tree_sum(b_tree_sum),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum)
  );

  logic signed [OW_B-1:0] b_stage;
  always @(posedge clk) begin
    if (b_tree_reset) b_stage <= '0;
    else if (b_tree_advance) b_stage <= OW_B'(b_tree_addends[0]) + OW_B'(b_tree_addends[1]);
  end
  assign b_tree_sum = b_stage;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [OW_A-1:0] exp_q[$];
  int pop_cyc[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every accepted output of A is compared against the head of exp_q
  always @(negedge clk) begin
    if (reset && a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_sum", int'(a_out_sum), 9999);
      end else begin
        check("sb_sum", int'(a_out_sum), int'($signed(exp_q.pop_front())));
      end
      pop_cyc.push_back(cyc);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int vals [LEN_A];
    int exp_sum;
  } vec_t;
  vec_t tbl [6];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int v, input int gap_pct);
    int guard;
    guard = 0;
    while ($urandom_range(99, 0) < gap_pct) begin
      a_in_valid = 1'b0;
      step();
    end
    a_in_valid = 1'b1;
    a_in_data  = DW_A'(v);
    while (!a_in_ready) begin
      step();
      guard++;
      if (guard > 2000) begin
        check("send_timeout", 0, 1);
        a_in_valid = 1'b0;
        return;
      end
    end
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s;
    bit done;
    int base;

    for (int i = 0; i < LEN_A; i++) begin
      tbl[0].vals[i] = (i % 2 == 0) ? (i + 1) : -(i + 1);
      tbl[1].vals[i] = -16;
      tbl[2].vals[i] = 15;
      tbl[3].vals[i] = 1;
      tbl[4].vals[i] = -1;
      tbl[5].vals[i] = 2;
    end
    tbl[0].exp_sum = 5;
    tbl[1].exp_sum = -144;
    tbl[2].exp_sum = 135;
    tbl[3].exp_sum = 9;
    tbl[4].exp_sum = -9;
    tbl[5].exp_sum = 18;

    // reset state
    reset = 1'b0;
    repeat (3) step();
    check("rst_tree_reset", int'(a_tree_reset), 1);
    check("rst_tree_advance", int'(a_tree_advance), 0);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_out_sum", int'(a_out_sum), 0);
    check("rst_addend0", int'(a_tree_addends[0]), 0);
    check("rst_in_ready", int'(a_in_ready), 1);
    reset = 1'b1;
    step();
    check("run_tree_reset", int'(a_tree_reset), 0);
    check("run_tree_advance", int'(a_tree_advance), 1);

    // single group: exact latency and in_ready profile
    exp_q.push_back(OW_A'(tbl[0].exp_sum));
    for (int i = 0; i < LEN_A; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = DW_A'(tbl[0].vals[i]);
      check("fill_in_ready", int'(a_in_ready), 1);
      step();
    end
    a_in_valid = 1'b0;
    check("issue_in_ready", int'(a_in_ready), 0);
    check("issue_advance", int'(a_tree_advance), 1);
    for (int i = 0; i < LEN_A; i++) check("addend_order", int'(a_tree_addends[i]), tbl[0].vals[i]);
    step();  // issue edge
    check("post_issue_in_ready", int'(a_in_ready), 1);
    for (int k = 0; k < LAT_A; k++) begin
      check("latency_not_yet", int'(a_out_valid), 0);
      step();
    end
    check("latency_valid", int'(a_out_valid), 1);
    check("latency_sum", int'(a_out_sum), 5);
    step();
    check("popped_valid", int'(a_out_valid), 0);
    wait_drain(50);

    // table pass: every group back to back at full rate
    pop_cyc.delete();
    for (int g = 0; g < 6; g++) begin
      exp_q.push_back(OW_A'(tbl[g].exp_sum));
      for (int i = 0; i < LEN_A; i++) send_a(tbl[g].vals[i], 0);
    end
    wait_drain(200);
    check("table_pop_count", pop_cyc.size(), 6);
    for (int g = 1; g < 6 && g < pop_cyc.size(); g++)
      check("group_period", pop_cyc[g] - pop_cyc[g-1], LEN_A + 1);

    // back-pressure: three groups with the consumer stalled
    a_out_ready = 1'b0;
    for (int g = 2; g <= 4; g++) begin
      exp_q.push_back(OW_A'(tbl[g].exp_sum));
      for (int i = 0; i < LEN_A; i++) send_a(tbl[g].vals[i], 0);
    end
    repeat (5) step();
    check("bp_valid", int'(a_out_valid), 1);
    check("bp_sum", int'(a_out_sum), 135);
    check("bp_advance", int'(a_tree_advance), 0);
    check("bp_in_ready", int'(a_in_ready), 0);
    repeat (20) step();
    check("bp_sum_held", int'(a_out_sum), 135);
    check("bp_advance_held", int'(a_tree_advance), 0);
    check("bp_queue_untouched", exp_q.size(), 3);
    a_out_ready = 1'b1;
    wait_drain(200);

    // random input gaps and random consumer readiness
    done = 1'b0;
    fork
      begin
        for (int g = 0; g < 6; g++) begin
          int vals [LEN_A];
          s = 0;
          for (int i = 0; i < LEN_A; i++) begin
            vals[i] = $urandom_range(31, 0) - 16;
            s += vals[i];
          end
          exp_q.push_back(OW_A'(s));
          for (int i = 0; i < LEN_A; i++) send_a(vals[i], 50);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          a_out_ready = 1'($urandom_range(1, 0));
          step();
        end
      end
    join
    a_out_ready = 1'b1;
    wait_drain(500);

    // reset mid-operation: held sum and partial group are discarded
    a_out_ready = 1'b0;
    for (int i = 0; i < LEN_A; i++) send_a(tbl[3].vals[i], 0);
    base = 0;
    while (!a_out_valid && base < 50) begin
      step();
      base++;
    end
    check("pre_reset_held", int'(a_out_valid), 1);
    for (int i = 0; i < 5; i++) send_a(tbl[0].vals[i], 0);
    reset = 1'b0;
    #1;
    check("midrst_tree_reset", int'(a_tree_reset), 1);
    check("midrst_advance", int'(a_tree_advance), 0);
    step();
    reset = 1'b1;
    check("midrst_out_valid", int'(a_out_valid), 0);
    check("midrst_out_sum", int'(a_out_sum), 0);
    check("midrst_in_ready", int'(a_in_ready), 1);
    check("midrst_addend0", int'(a_tree_addends[0]), 0);
    a_out_ready = 1'b1;
    exp_q.push_back(OW_A'(tbl[5].exp_sum));
    for (int i = 0; i < LEN_A; i++) send_a(tbl[5].vals[i], 0);
    wait_drain(100);

    // instance B: LENGTH=2, latency 1
    b_in_valid = 1'b1;
    b_in_data  = DW_B'(7);
    check("b_ready0", int'(b_in_ready), 1);
    step();
    check("b_ready1", int'(b_in_ready), 1);
    step();
    b_in_valid = 1'b0;
    check("b_issue_ready", int'(b_in_ready), 0);
    check("b_issue_advance", int'(b_tree_advance), 1);
    check("b_addend0", int'(b_tree_addends[0]), 7);
    check("b_addend1", int'(b_tree_addends[1]), 7);
    step();
    check("b_lat_not_yet", int'(b_out_valid), 0);
    step();
    check("b_valid_14", int'(b_out_valid), 1);
    check("b_sum_14", int'(b_out_sum), 14);
    b_in_valid = 1'b1;
    b_in_data  = DW_B'(-8);
    step();
    step();
    b_in_valid = 1'b0;
    step();
    check("b_lat_not_yet2", int'(b_out_valid), 0);
    step();
    check("b_valid_m16", int'(b_out_valid), 1);
    check("b_sum_m16", int'(b_out_sum), -16);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
